// File: rtl/operand_capture.sv
// operand_capture: synchronizes the switches and the LOAD/CLEAR buttons,
// debounces the buttons, and latches two signed operands from the switches
// on a debounced LOAD press. The latched pair reaches the multiplier through
// one output register stage, so all outputs change together.
module operand_capture #(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*W-1:0]      sw,
    input  logic                btn_load,
    input  logic                btn_clear,
    output logic signed [W-1:0] in0,
    output logic signed [W-1:0] in1,
    output logic                valid,
    output logic                load_pulse,
    output logic [3:0]          load_count
);

    // Wide enough to hold DEB_CYCLES-1; the counter restarts there, so it never wraps.
    localparam int               CNT_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam int               B_LOAD   = 0;
    localparam int               B_CLEAR  = 1;

    typedef enum logic {
        S_EMPTY  = 1'b0,
        S_LOADED = 1'b1
    } state_t;

    logic [2*W-1:0]      r_sw_s1;
    logic [2*W-1:0]      r_sw_s2;
    logic [1:0]          r_btn_s1;
    logic [1:0]          r_btn_s2;
    logic [1:0]          r_stable;
    logic [1:0]          r_stable_q;
    logic [CNT_W-1:0]    r_deb_cnt [2];
    logic [1:0]          w_rise;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_do_load;
    logic                w_do_clear;

    logic signed [W-1:0] r_op0_p0;
    logic signed [W-1:0] r_op1_p0;
    logic [3:0]          r_cnt_p0;
    logic                r_pulse_p0;

    logic signed [W-1:0] r_in0_p1;
    logic signed [W-1:0] r_in1_p1;
    logic [3:0]          r_cnt_p1;
    logic                r_pulse_p1;
    logic                r_valid_p1;

    // Two-flop synchronizers for the switches and both buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= {btn_clear, btn_load};
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Debounce: accept a new button level only after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_btn_s2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == CNT_LAST) begin
                    r_stable[i]  <= r_btn_s2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Delayed copy of the debounced levels for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_q <= '0;
        end else begin
            r_stable_q <= r_stable;
        end
    end

    assign w_rise = r_stable & ~r_stable_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and load/clear decisions; CLEAR has priority over LOAD.
    always_comb begin
        w_state_nxt = r_state;
        w_do_load   = 1'b0;
        w_do_clear  = 1'b0;
        if (w_rise[B_CLEAR]) begin
            w_state_nxt = S_EMPTY;
            w_do_clear  = 1'b1;
        end else if (w_rise[B_LOAD]) begin
            w_state_nxt = S_LOADED;
            w_do_load   = 1'b1;
        end
    end

    // Operand latch, load counter and strobe, updated on the rise cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op0_p0   <= '0;
            r_op1_p0   <= '0;
            r_cnt_p0   <= '0;
            r_pulse_p0 <= 1'b0;
        end else if (w_do_clear) begin
            r_op0_p0   <= '0;
            r_op1_p0   <= '0;
            r_cnt_p0   <= '0;
            r_pulse_p0 <= 1'b0;
        end else if (w_do_load) begin
            r_op0_p0   <= r_sw_s2[W-1:0];
            r_op1_p0   <= r_sw_s2[2*W-1:W];
            r_cnt_p0   <= r_cnt_p0 + 4'd1;
            r_pulse_p0 <= 1'b1;
        end else begin
            r_pulse_p0 <= 1'b0;
        end
    end

    // Output register stage feeding the multiplier; keeps all outputs aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in0_p1   <= '0;
            r_in1_p1   <= '0;
            r_cnt_p1   <= '0;
            r_pulse_p1 <= 1'b0;
            r_valid_p1 <= 1'b0;
        end else begin
            r_in0_p1   <= r_op0_p0;
            r_in1_p1   <= r_op1_p0;
            r_cnt_p1   <= r_cnt_p0;
            r_pulse_p1 <= r_pulse_p0;
            r_valid_p1 <= (r_state == S_LOADED);
        end
    end

    assign in0        = r_in0_p1;
    assign in1        = r_in1_p1;
    assign valid      = r_valid_p1;
    assign load_pulse = r_pulse_p1;
    assign load_count = r_cnt_p1;

endmodule
